load_read_unit: RTL and testbench
=================================

LOAD_READ_UNIT -- requirements
Module: load_read_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1, a load request from the MEM stage.
REQ-004 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-005 SHALL have port addr, input, 32, the load byte address.
REQ-006 SHALL have port ld_type, input, 3, with codes 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 are illegal.
REQ-007 SHALL have port mem_req, output, 1, a read request to data memory.
REQ-008 SHALL have port mem_addr, output, 32, equal to {addr[31:2],2'b00} of the captured request.
REQ-009 SHALL have port mem_gnt, input, 1, memory accepts mem_req.
REQ-010 SHALL have port mem_rvalid, input, 1, and port mem_rdata, input, 32, the read return.
REQ-011 SHALL have ports rsp_valid, output, 1; rsp_data, output, 32; rsp_err, output, 1; and rsp_ready, input, 1.
REQ-012 SHALL have port busy, output, 1, a pipeline stall, high whenever state != IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, REQ, WAIT and RESP.
REQ-014 IDLE: on req_valid, SHALL capture addr, ld_type and lane = addr[1:0].
- Aligned and legal request: go to REQ.
- Otherwise: go to RESP with rsp_err=1 and rsp_data=0, with no memory access.
REQ-015 SHALL treat a request as misaligned when it is LW with lane!=00, or LH/LHU with lane[0]=1.
REQ-016 REQ: SHALL hold mem_req=1 with mem_addr stable until mem_gnt, then go to WAIT.
REQ-017 WAIT: on mem_rvalid, SHALL register the extracted and extended data into rsp_data, set rsp_err=0, and go to RESP.
REQ-018 SHALL ignore mem_rvalid outside WAIT.
REQ-019 WAIT: SHALL increment an 8-bit watchdog counter each cycle.
- Counter reaches TIMEOUT (255) without mem_rvalid: go to RESP with rsp_err=1 and rsp_data=0.
- mem_rvalid on the same cycle as timeout: data wins.
REQ-020 RESP: SHALL hold rsp_valid=1 with data and err stable until rsp_ready=1, then return to IDLE.
REQ-021 SHALL NOT accept a new request in the RESP-exit cycle; minimum request spacing is one IDLE cycle.
REQ-022 Extraction SHALL be little-endian by lane.
- LB/LBU: byte lane selects mem_rdata[8*lane+7 : 8*lane].
- LH/LHU: lane 00 selects [15:0]; lane 10 selects [31:16].
REQ-023 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass through unchanged.
REQ-024 Minimum latency, with mem_gnt immediate and mem_rvalid one cycle later: accept at cycle 0, mem_req at cycle 1, rsp_valid at cycle 3.
REQ-025 The watchdog SHALL clear on every entry to WAIT.

Reset
REQ-026 With reset_n=0 at a clock edge, the block SHALL enter IDLE with outputs as follows.
- mem_req=0, rsp_valid=0, rsp_err=0, busy=0.
- rsp_data=0, mem_addr=0, watchdog=0.
- req_ready=1 after the edge.
REQ-027 Reset in REQ, WAIT or RESP SHALL abandon the transaction; a late mem_rvalid after reset SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the ld_type codes, the state encoding and the TIMEOUT constant.
REQ-029 Lane selection and extension SHALL live in a combinational sub-module load_extract (inputs rdata, lane, ld_type; output 32-bit data), instanced once.

Verification
REQ-030 LB, addr=0x1003, rdata=0x80FF_1234, gnt immediate, rvalid +1 -> rsp_data=0xFFFF_FF80, err=0, rsp_valid at cycle 3.
REQ-031 LHU, addr=0x2002, rdata=0x9ABC_5678 -> rsp_data=0x0000_9ABC; the same access as LH -> 0xFFFF_9ABC.
REQ-032 LW, addr=0x3001 -> mem_req never asserted; rsp_valid at cycle 1 with err=1 and data=0.
REQ-033 LW, gnt held low 4 cycles then high, no rvalid -> mem_addr stable throughout; rsp_err=1 after 255 WAIT cycles.
REQ-034 rsp_ready held low 3 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0; then one IDLE cycle before the next accept.
REQ-035 reset_n low during WAIT, then rvalid pulse -> IDLE, rsp_valid stays 0, busy=0.

Source files
------------

// File: rtl/load_read_unit_pkg.sv
// Shared definitions for the load read unit: load-type codes, FSM state
// encoding, watchdog limit and request-legality helpers.
package load_read_unit_pkg;

    // Load-type encodings as presented on ld_type
    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    // Watchdog limit for an outstanding memory read
    localparam logic [7:0] TIMEOUT = 8'd255;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lru_state_t;

    // True for the five defined load types; 101-111 are rejected
    function automatic logic ld_type_legal(input logic [2:0] ld_type);
        logic legal;
        case (ld_type)
            LD_LW, LD_LB, LD_LBU, LD_LH, LD_LHU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Word loads need lane 00; halfword loads need an even lane
    function automatic logic ld_misaligned(input logic [2:0] ld_type,
                                           input logic [1:0] lane);
        logic mis;
        case (ld_type)
            LD_LW:         mis = (lane != 2'b00);
            LD_LH, LD_LHU: mis = lane[0];
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a returned data word.
// Byte order is little-endian: lane 0 is rdata[7:0].
module load_extract
    import load_read_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword, then extend per load type
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;

        case (lane)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase

        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end

        case (ld_type)
            LD_LW:   data = rdata;
            LD_LB:   data = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  data = {24'h00_0000, byte_s};
            LD_LH:   data = {{16{half_s[15]}}, half_s};
            LD_LHU:  data = {16'h0000, half_s};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_read_unit.sv
// Load read unit: accepts one load from the MEM stage, issues a word read to
// data memory, extracts/extends the addressed lane and hands the result back
// through a valid/ready response port. Misaligned or illegal requests are
// answered with an error without touching memory; a watchdog bounds the wait
// for read data.
module load_read_unit
    import load_read_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [2:0]  ld_type,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic        busy
);

    lru_state_t  state_r;
    logic [2:0]  ld_type_r;
    logic [1:0]  lane_r;
    logic [7:0]  wdog_r;

    logic [31:0] ext_data_s;
    logic        req_ok_s;
    logic [7:0]  wdog_next_s;
    logic        wdog_expired_s;

    load_extract u_extract (
        .rdata   (mem_rdata),
        .lane    (lane_r),
        .ld_type (ld_type_r),
        .data    (ext_data_s)
    );

    // Request legality and watchdog next-value decode
    always_comb begin
        req_ok_s       = ld_type_legal(ld_type) && !ld_misaligned(ld_type, addr[1:0]);
        wdog_next_s    = wdog_r + 8'd1;
        wdog_expired_s = (wdog_next_s == TIMEOUT);
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ld_type_r <= LD_LW;
            lane_r    <= 2'b00;
            wdog_r    <= 8'd0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        ld_type_r <= ld_type;
                        lane_r    <= addr[1:0];
                        mem_addr  <= {addr[31:2], 2'b00};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_ok_s) begin
                            mem_req <= 1'b1;
                            state_r <= ST_REQ;
                        end else begin
                            // Rejected request: answer immediately, no memory access
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 32'h0000_0000;
                            state_r   <= ST_RESP;
                        end
                    end
                end

                ST_REQ: begin
                    // mem_req and mem_addr stay put until the grant
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        wdog_r  <= 8'd0;
                        state_r <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    wdog_r <= wdog_next_s;
                    // Returned data takes priority over an expiring watchdog
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= ext_data_s;
                        state_r   <= ST_RESP;
                    end else if (wdog_expired_s) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= 32'h0000_0000;
                        state_r   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // req_ready rises only after this exit edge, forcing an IDLE gap
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_read_unit.sv
// Scoreboard bench for load_read_unit: stimulus pushes expected responses,
// a monitor pops and compares on each new rsp_valid.
module tb_load_read_unit;
    import load_read_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [2:0]  ld_type;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    load_read_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .addr       (addr),
        .ld_type    (ld_type),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    // Monitor: compare each newly presented response against the scoreboard
    initial begin : monitor
        logic  prev_valid;
        exp_t  e;
        string nm;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got data 0x%08h err %0d, expected no response",
                             rsp_data, rsp_err);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_data"}, rsp_data, e.data);
                    check({nm, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
            prev_valid = rsp_valid;
        end
    end

    // One load transaction with a scripted memory and response sink
    task automatic run_load(input string nm, input logic [31:0] a, input logic [2:0] t,
                            input logic [31:0] rd, input int gnt_dly, input bit give_rv,
                            input int rdy_dly, input logic [31:0] exp_d, input logic exp_e,
                            input bit exp_mem, input int exp_lat);
        int          cyc;
        int          gnt_cnt;
        int          rdy_cnt;
        bit          seen_mem;
        bit          granted;
        bit          rv_sent;
        bit          first;
        bit          done;
        logic [31:0] held_d;
        logic        held_e;
        exp_t        e;

        cyc = 0; gnt_cnt = 0; rdy_cnt = 0;
        seen_mem = 1'b0; granted = 1'b0; rv_sent = 1'b0; first = 1'b0; done = 1'b0;
        held_d = 32'h0; held_e = 1'b0;

        e.data = exp_d;
        e.err  = exp_e;
        exp_q.push_back(e);
        name_q.push_back(nm);

        @(negedge clk);
        check({nm, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        addr      = a;
        ld_type   = t;
        @(negedge clk);
        // Scramble the request inputs to prove the DUT captured them
        req_valid = 1'b0;
        addr      = 32'hDEAD_BEEF;
        ld_type   = 3'b111;
        cyc       = 1;

        while (!done && cyc < 1000) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            rsp_ready  = 1'b0;
            mem_rdata  = ~rd;
            if (rsp_valid) begin
                if (!first) begin
                    first  = 1'b1;
                    held_d = rsp_data;
                    held_e = rsp_err;
                    check({nm, "_latency"}, cyc, exp_lat);
                    check({nm, "_mem_req_seen"}, {31'd0, seen_mem}, {31'd0, exp_mem});
                end else begin
                    check({nm, "_data_stable"}, rsp_data, held_d);
                    check({nm, "_err_stable"}, {31'd0, rsp_err}, {31'd0, held_e});
                end
                check({nm, "_req_ready_resp"}, {31'd0, req_ready}, 32'd0);
                check({nm, "_busy_resp"}, {31'd0, busy}, 32'd1);
                // Spurious return outside WAIT must be ignored
                mem_rvalid = 1'b1;
                if (rdy_cnt >= rdy_dly) begin
                    rsp_ready = 1'b1;
                    done      = 1'b1;
                end else begin
                    rdy_cnt++;
                end
            end else if (mem_req) begin
                seen_mem = 1'b1;
                check({nm, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
                if (gnt_cnt >= gnt_dly) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                end else begin
                    gnt_cnt++;
                    mem_rvalid = 1'b1;
                end
            end else if (granted && give_rv && !rv_sent) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                rv_sent    = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        rsp_ready  = 1'b0;

        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no completed response, expected one within 1000 cycles", nm);
        end else begin
            check({nm, "_rsp_valid_after"}, {31'd0, rsp_valid}, 32'd0);
            check({nm, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
            check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
        end
    endtask

    // Global time bound
    initial begin : time_guard
        #500000;
        $display("FAIL time_guard: got simulation still running, expected completion");
        $fatal(1, "time bound exceeded");
    end

    // Stimulus
    initial begin : stim
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        addr       = 32'h0;
        ld_type    = LD_LW;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_rsp_data",  rsp_data,           32'h0);
        check("rst_mem_addr",  mem_addr,           32'h0);

        //       name          addr          type     rdata          gnt rv  rdy exp_data       err  mem lat
        run_load("lb_lane3",   32'h0000_1003, LD_LB,  32'h80FF_1234, 0, 1'b1, 0, 32'hFFFF_FF80, 1'b0, 1'b1, 3);
        run_load("lhu_lane2",  32'h0000_2002, LD_LHU, 32'h9ABC_5678, 0, 1'b1, 0, 32'h0000_9ABC, 1'b0, 1'b1, 3);
        run_load("lh_lane2",   32'h0000_2002, LD_LH,  32'h9ABC_5678, 0, 1'b1, 0, 32'hFFFF_9ABC, 1'b0, 1'b1, 3);
        run_load("lw_misal",   32'h0000_3001, LD_LW,  32'h1234_5678, 0, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_load("lw_timeout", 32'h0000_4000, LD_LW,  32'h5555_AAAA, 4, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b1, 261);
        run_load("lbu_stall",  32'h0000_5001, LD_LBU, 32'h1234_F0AB, 0, 1'b1, 3, 32'h0000_00F0, 1'b0, 1'b1, 3);
        run_load("lh_lane0",   32'h0000_6000, LD_LH,  32'h0000_8001, 0, 1'b1, 0, 32'hFFFF_8001, 1'b0, 1'b1, 3);
        run_load("lw_gnt2",    32'h0000_7000, LD_LW,  32'hCAFE_BABE, 2, 1'b1, 0, 32'hCAFE_BABE, 1'b0, 1'b1, 5);
        run_load("lb_pos",     32'h0000_8000, LD_LB,  32'h0000_007F, 0, 1'b1, 0, 32'h0000_007F, 1'b0, 1'b1, 3);
        run_load("illegal_ty", 32'h0000_9000, 3'b101, 32'h1111_2222, 0, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_load("lh_misal",   32'h0000_A001, LD_LH,  32'h1111_2222, 0, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_load("lhu_misal",  32'h0000_A003, LD_LHU, 32'h1111_2222, 0, 1'b1, 1, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_load("lb_lane2",   32'h0000_B002, LD_LB,  32'h00AB_0000, 0, 1'b1, 0, 32'hFFFF_FFAB, 1'b0, 1'b1, 3);
        run_load("lhu_lane0",  32'h0000_C000, LD_LHU, 32'h1234_FEDC, 0, 1'b1, 0, 32'h0000_FEDC, 1'b0, 1'b1, 3);

        // Reset while waiting for read data, then a late return
        @(negedge clk);
        req_valid = 1'b1;
        addr      = 32'h0000_D000;
        ld_type   = LD_LW;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw_mem_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rstw_busy_wait", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstw_busy",      {31'd0, busy},      32'd0);
        check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstw_mem_req",   {31'd0, mem_req},   32'd0);
        check("rstw_mem_addr",  mem_addr,           32'h0);
        check("rstw_rsp_data",  rsp_data,           32'h0);
        for (int i = 0; i < 3; i++) begin
            check("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
